// File: rtl/data_mem_responder.sv
// Word-access memory responder: captures a load/store request, inserts
// WAIT_CYCLES wait states, then answers with a one-cycle ack/err/rdata strobe.
module data_mem_responder #(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WLOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic          cap_we;
  logic [7:0]    mem [DEPTH_BYTES];

  logic          accept;
  logic          enter_resp;
  logic          acc_we;
  logic          acc_bad;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] idx;

  // With zero wait states the access completes on the accepting edge itself,
  // so the live inputs stand in for the not-yet-loaded capture registers.
  always_comb begin
    accept     = (state == IDLE) && req;
    enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));
    acc_addr   = accept ? addr  : cap_addr;
    acc_wdata  = accept ? wdata : cap_wdata;
    acc_we     = accept ? we    : cap_we;
    acc_bad    = (acc_addr[1:0] != 2'b00) ||
                 (({1'b0, acc_addr} + 33'd3) >= 33'(DEPTH_BYTES));
    idx        = acc_addr[AW-1:0];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_we    <= we;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WLOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= enter_resp;
      err   <= enter_resp && acc_bad;
      if (enter_resp && !acc_bad && !acc_we)
        rdata <= {mem[idx], mem[idx + AW'(1)], mem[idx + AW'(2)], mem[idx + AW'(3)]};
      else
        rdata <= '0;
    end
  end

  // Storage is deliberately not reset; the reset term only blocks a write
  // while the block is being held in reset.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_we && !acc_bad) begin
      mem[idx]          <= acc_wdata[31:24];
      mem[idx + AW'(1)] <= acc_wdata[23:16];
      mem[idx + AW'(2)] <= acc_wdata[15:8];
      mem[idx + AW'(3)] <= acc_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: scoreboard-checked instance with 2 wait states, plus a
// zero-wait-state instance exercised with req held high.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ack, err, busy;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [31:0] rdata0;
  logic        ack0, err0, busy0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_on = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;
  exp_t sb[$];

  data_mem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  data_mem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      chk("busy", 32'(busy), 32'((sb.size() > 0) && (cyc >= sb[0].acc)));
      if (ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          chk("rdata", rdata, sb[0].rdata);
          chk("err", 32'(err), 32'(sb[0].err));
          chk("latency", 32'(cyc - sb[0].acc), 32'd2);
          void'(sb.pop_front());
        end
      end else begin
        chk("idle_rdata", rdata, 32'd0);
        chk("idle_err", 32'(err), 32'd0);
      end
    end
  end

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    e.rdata = exp_rd; e.err = exp_err; e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk("ack_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd);
    @(negedge clk);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(negedge clk);
    chk("z_ack", 32'(ack0), 32'd1);
    chk("z_rdata", rdata0, exp_rd);
    chk("z_err", 32'(err0), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b1;
    mon_on = 1'b1;

    access(1'b1, 32'h10, 32'h12345678, 32'h0, 1'b0);
    access(1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);
    chk("byte_10", 32'(dut.mem[16]), 32'h12);
    chk("byte_13", 32'(dut.mem[19]), 32'h78);

    access(1'b1, 32'h12, 32'hA5A5A5A5, 32'h0, 1'b1);
    access(1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);

    access(1'b1, 32'h7C, 32'hCAFEF00D, 32'h0, 1'b0);
    access(1'b0, 32'h7C, 32'h0, 32'hCAFEF00D, 1'b0);
    access(1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
    access(1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);
    access(1'b1, 32'h7D, 32'h11111111, 32'h0, 1'b1);
    access(1'b0, 32'h7C, 32'h0, 32'hCAFEF00D, 1'b0);
    access(1'b1, 32'h04, 32'h01020304, 32'h0, 1'b0);
    access(1'b0, 32'h04, 32'h0, 32'h01020304, 1'b0);

    // Reset during WAIT must abandon the store.
    access(1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
    mon_on = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_cnt", 32'(dut.cnt), 32'd0);
    chk("mid_rst_cap", dut.cap_addr, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_ack", 32'(ack), 32'd0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ack", 32'(ack), 32'd0);
    end
    mon_on = 1'b1;
    access(1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

    // Zero wait states: sentinels in odd word slots expose duplicated acceptances.
    mon_on = 1'b0;
    for (int k = 1; k < 8; k += 2) acc0(1'b1, 32'(4 * k), 32'hFFFFFFFF, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'(4 * k); wdata0 = 32'(k);
      @(posedge clk);
      @(negedge clk);
      chk("z_st_ack", 32'(ack0), 32'(k % 2 == 0));
      chk("z_st_busy", 32'(busy0), 32'(k % 2 == 0));
    end
    for (int k = 0; k < 8; k++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'(4 * k); wdata0 = '0;
      @(posedge clk);
      @(negedge clk);
      chk("z_ld_ack", 32'(ack0), 32'(k % 2 == 0));
      chk("z_ld_busy", 32'(busy0), 32'(k % 2 == 0));
      chk("z_ld_rdata", rdata0, (k % 2 == 0) ? 32'(k) : 32'd0);
    end
    req0 = 1'b0;
    @(negedge clk);
    for (int k = 1; k < 8; k += 2) acc0(1'b0, 32'(4 * k), 32'h0, 32'hFFFFFFFF);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
